// File: rtl/region_tracer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// region_tracer_pkg : shared types, widths and trace-mode encodings
// Rev 1.0
// ----------------------------------------------------------------------------
package region_tracer_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_TS_W   = 16;

  function automatic int entry_w(input int num_ch, input int ts_w);
    return ts_w + 2 * num_ch;
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int ENTRY_W = entry_w(DEF_NUM_CH, DEF_TS_W);

  // Layout matches the packed rd_data bus of the tracer at default sizes.
  typedef struct packed {
    logic [DEF_TS_W-1:0]   ts;
    logic [DEF_NUM_CH-1:0] q_pre;
    logic [DEF_NUM_CH-1:0] q_post;
  } trace_entry_t;

  localparam logic TM_ALL    = 1'b0;
  localparam logic TM_CHANGE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trace_fifo : synchronous first-word fall-through FIFO, accepts push when full
//              if a pop happens in the same cycle
// Rev 1.0
// ----------------------------------------------------------------------------
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra MSB on the pointers distinguishes full from empty.
  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/region_toggle_tracer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// region_toggle_tracer : divided toggle channels with pre/post-edge trace FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module region_toggle_tracer
  import region_tracer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] div_cfg,
  output logic [NUM_CH-1:0]       q,
  input  logic                    trace_en,
  input  logic                    trace_mode,
  output logic [TS_W+2*NUM_CH-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int EW = entry_w(NUM_CH, TS_W);

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [NUM_CH-1:0] q_q, q_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, fifo_full, fifo_empty;
  logic [EW-1:0]     push_data;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] div, cnt_q, cnt_d;
    logic             tog;

    assign div = div_cfg[i*CNT_W +: CNT_W];

    // Equality compare only: a div lowered below cnt wraps around before matching.
    always_comb begin
      cnt_d = cnt_q;
      tog   = 1'b0;
      if (ch_en[i]) begin
        if (cnt_q == div) begin
          cnt_d = '0;
          tog   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign q_d[i] = q_q[i] ^ tog;
  end

  always_comb begin
    ts_d      = ts_q + 1'b1;
    pop       = rd_ready && !fifo_empty;
    push      = trace_en && ((trace_mode == TM_ALL) || (q_q != q_d));
    push_data = {ts_q, q_q, q_d};
    ovf_d     = ovf_q;
    if (ovf_clr)                     ovf_d = 1'b0;
    if (push && fifo_full && !pop)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q  <= '0;
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      ts_q  <= ts_d;
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign q        = q_q;
  assign rd_valid = !fifo_empty;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_region_toggle_tracer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_region_toggle_tracer : directed stimulus with queue scoreboard and monitor
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_region_toggle_tracer;
  import region_tracer_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int TS_W   = 16;
  localparam int DEPTH  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*CNT_W-1:0] div_cfg;
  logic [NUM_CH-1:0]       q;
  logic                    trace_en;
  logic                    trace_mode;
  logic [TS_W+2*NUM_CH-1:0] rd_data;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [$clog2(DEPTH):0]  level;
  logic                    ovf;
  logic                    ovf_clr;

  int           checks = 0;
  int           errors = 0;
  trace_entry_t exp_q[$];
  trace_entry_t mon_e;

  region_toggle_tracer #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .TS_W   (TS_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_en      (ch_en),
    .div_cfg    (div_cfg),
    .q          (q),
    .trace_en   (trace_en),
    .trace_mode (trace_mode),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .level      (level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Closed form: after edge k a channel has toggled floor((k+1)/(div+1)) times.
  function automatic logic [3:0] qexp(input int k, input logic [3:0] en, input logic [31:0] divs);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = int'(divs[i*8 +: 8]);
      if (en[i] && k >= 0) r[i] = (((k + 1) / (d + 1)) % 2) == 1;
    end
    return r;
  endfunction

  function automatic trace_entry_t mk(input int k, input logic [3:0] en, input logic [31:0] divs);
    trace_entry_t e;
    e.ts     = 16'(k);
    e.q_pre  = qexp(k - 1, en, divs);
    e.q_post = qexp(k, en, divs);
    return e;
  endfunction

  // Monitor: samples just before the edge at which a pop will occur.
  always begin
    @(negedge clk);
    #4;
    if (rst_n === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got=%h want=none t=%0t", rd_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_entry", 32'(rd_data), 32'(mon_e));
      end
    end
  end

  task automatic idle_inputs();
    ch_en      = '0;
    div_cfg    = '0;
    trace_en   = 1'b0;
    trace_mode = TM_ALL;
    rd_ready   = 1'b0;
    ovf_clr    = 1'b0;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_cfg(input logic [3:0] en, input logic [31:0] divs,
                             input logic mode, input logic rdy);
    ch_en      = en;
    div_cfg    = divs;
    trace_mode = mode;
    trace_en   = 1'b1;
    rd_ready   = rdy;
    rst_n      = 1'b1;
  endtask

  task automatic drain(input string nm);
    trace_en = 1'b0;
    rd_ready = 1'b1;
    repeat (DEPTH + 2) @(negedge clk);
    check({nm, "_level_empty"}, 32'(level), 32'd0);
    check({nm, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // Legacy single channel, div=0
    for (int k = 0; k < 6; k++) exp_q.push_back(mk(k, 4'b0001, 32'h0));
    release_cfg(4'b0001, 32'h0, TM_ALL, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("p1_q", 32'(q), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    drain("p1");
    enter_reset();

    // Divide ratios 0,1,3,7
    for (int k = 0; k < 20; k++) exp_q.push_back(mk(k, 4'hF, 32'h07030100));
    release_cfg(4'hF, 32'h07030100, TM_ALL, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("p2_q", 32'(q), 32'(qexp(k, 4'hF, 32'h07030100)));
    end
    drain("p2");
    enter_reset();

    // Change-only capture, channel 2 with div=3
    exp_q.push_back('{ts: 16'd3,  q_pre: 4'b0000, q_post: 4'b0100});
    exp_q.push_back('{ts: 16'd7,  q_pre: 4'b0100, q_post: 4'b0000});
    exp_q.push_back('{ts: 16'd11, q_pre: 4'b0000, q_post: 4'b0100});
    exp_q.push_back('{ts: 16'd15, q_pre: 4'b0100, q_post: 4'b0000});
    release_cfg(4'b0100, 32'h00030000, TM_CHANGE, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("p3_level", 32'(level), (k % 4 == 3) ? 32'd1 : 32'd0);
    end
    drain("p3");
    enter_reset();

    // Overflow with consumer stalled
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(k, 4'b0001, 32'h0));
    release_cfg(4'b0001, 32'h0, TM_ALL, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("p4_level", 32'(level), (k < 8) ? 32'(k + 1) : 32'd8);
      check("p4_ovf", 32'(ovf), (k >= 8) ? 32'd1 : 32'd0);
    end
    check("p4_head_valid", 32'(rd_valid), 32'd1);
    check("p4_head_ts", 32'(rd_data[TS_W+2*NUM_CH-1 -: TS_W]), 32'd0);
    trace_en = 1'b0;
    ovf_clr  = 1'b1;
    @(negedge clk);
    check("p4_ovf_clr", 32'(ovf), 32'd0);
    check("p4_level_hold", 32'(level), 32'd8);
    trace_en = 1'b1;
    @(negedge clk);
    check("p4_set_wins", 32'(ovf), 32'd1);
    trace_en = 1'b0;
    @(negedge clk);
    check("p4_ovf_clr2", 32'(ovf), 32'd0);

    // Full with simultaneous pop at edge 13
    ovf_clr  = 1'b0;
    trace_en = 1'b1;
    rd_ready = 1'b1;
    exp_q.push_back(mk(13, 4'b0001, 32'h0));
    @(negedge clk);
    rd_ready = 1'b0;
    trace_en = 1'b0;
    check("p5_level", 32'(level), 32'd8);
    check("p5_ovf", 32'(ovf), 32'd0);
    drain("p5");
    enter_reset();

    // Asynchronous reset mid-operation
    release_cfg(4'b0001, 32'h0, TM_ALL, 1'b0);
    repeat (5) @(negedge clk);
    check("p6_level_pre", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("p6_async_valid", 32'(rd_valid), 32'd0);
    check("p6_async_level", 32'(level), 32'd0);
    check("p6_async_q", 32'(q), 32'd0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(k, 4'b0001, 32'h0));
    release_cfg(4'b0001, 32'h0, TM_ALL, 1'b1);
    repeat (4) @(negedge clk);
    drain("p6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/region_toggle_tracer.md
Name: region_toggle_tracer

Overview:
- Parametrised, synthesizable successor to the single-bit toggle/visibility demo.
- NUM_CH independent toggle channels, each with a runtime divide ratio and enable.
- A trace unit records, per capture cycle, a timestamp plus each channel's pre-edge value (what an active-region reader sees) and post-edge value (what a postponed-region reader sees).
- Entries go into a FIFO drained over a valid/ready port; used as a scheduling-semantics checker and a clock-derived stimulus source in benches.

Parameters:
- NUM_CH, 4, number of toggle channels (1..32).
- CNT_W, 8, width of each channel divide counter.
- TS_W, 16, timestamp width, in clk cycles.
- DEPTH, 8, trace FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel run enable.
- div_cfg  in  NUM_CH*CNT_W  per-channel divide ratio; channel i uses slice [i*CNT_W +: CNT_W].
- q  out  NUM_CH  channel toggle outputs, registered.
- trace_en  in  1  capture enable.
- trace_mode  in  1  0 = capture every cycle; 1 = capture only cycles where at least one channel toggles.
- rd_data  out  TS_W+2*NUM_CH  head entry, packed {ts, q_pre, q_post}.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts head.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (rst_n low, async): q=0, all cnt=0, ts=0, FIFO empty, rd_valid=0, level=0, ovf=0. rd_data is don't-care while rd_valid=0.
- Asserting reset mid-operation discards all FIFO contents. Release is synchronous to the next posedge.

Timestamp:
- ts increments by 1 every cycle out of reset and wraps from 2^TS_W-1 to 0.

Channel i:
- If ch_en[i]=0, cnt and q[i] hold.
- If ch_en[i]=1 and cnt==div: q[i] toggles and cnt returns to 0. Otherwise cnt increments.
- div=0 toggles every cycle, which reproduces the legacy behaviour.
- Changing div_cfg takes effect on the next compare.
- If div is reduced below the current cnt, cnt counts up, wraps through 2^CNT_W, and then matches. This is intentional and must not be patched.
- Toggle period is 2*(div+1) cycles.

Capture at posedge N:
- q_pre = q before edge N; q_post = q after edge N; ts = ts value before edge N.
- Capture condition: trace_en && (trace_mode==0 || q_pre != q_post).
- The entry is pushed at edge N and visible on rd_data/rd_valid from edge N onward. Latency is 0 cycles after the push edge (first-word fall-through).

Pop:
- A pop occurs when rd_valid && rd_ready at a posedge.
- rd_ready is ignored when empty.

Full and overflow:
- When full with no pop that cycle, the push is dropped (FIFO contents unchanged) and ovf sets.
- When full with a simultaneous pop, the push is accepted and level stays at DEPTH.
- ovf_clr and a new overflow in the same cycle leave ovf=1 (set wins).

Other boundaries:
- Simultaneous push and pop when empty: the push is accepted, the pop is ignored, and level becomes 1.
- level is always in 0..DEPTH and is updated at the same edge as push/pop.
- Pointers use an extra wrap bit for full/empty detection.

Decomposition:
- Package region_tracer_pkg holds:
  - the localparam for entry width;
  - the packed struct trace_entry_t {ts, q_pre, q_post}, parametrised through package-level defaults plus width functions;
  - the trace_mode encoding constants TM_ALL=0 and TM_CHANGE=1.
- Sub-module trace_fifo: a generic synchronous FIFO (WIDTH, DEPTH) with first-word fall-through, push/pop/full/empty/level, and the full-with-pop accept rule.
- Channel counters and capture logic stay in the top module as a generate loop.

Test Plan:
- Reset/default: hold rst_n=0 for 3 cycles, then release with ch_en=1 on channel 0, div=0, trace_en=1, mode=0, rd_ready=1. Required: q[0] toggles every cycle; first entry is {ts=0, q_pre=0, q_post=1}; second entry is {ts=1, q_pre=1, q_post=0}.
- Divide ratios: div = {0,1,3,7} on channels 0..3, all enabled. Required: first toggles at cycles 0, 1, 3, 7 after release; periods are 2, 4, 8, 16 cycles.
- Change-only trace: mode=1, channel 2 only with div=3. Required: entries are pushed only at toggle edges, with ts values 3, 7, 11, …
- Overflow: DEPTH=8, mode=0, rd_ready=0 for 10 cycles. Required: level saturates at 8; ovf=1 from the 9th push; head entry has ts=0. Then pulse ovf_clr. Required: ovf=0.
- Full plus simultaneous pop: with the FIFO full, raise rd_ready for 1 cycle while capturing. Required: level stays 8; the new tail is the entry from that cycle; ovf does not set.
- Mid-operation reset: assert rst_n=0 asynchronously between edges with level=5. Required: rd_valid=0, level=0, and q=0 immediately, before the next edge; after release, ts restarts at 0.
